ifetch: RTL and testbench

IFETCH -- requirements
Module: ifetch

---
 rtl/mips_pkg.sv | 23 ++
 rtl/pc_next.sv | 27 ++
 rtl/ifetch.sv | 169 ++++++++++++++++
 tb/tb_ifetch.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared fetch state encoding, opcode constants and reset vector
package mips_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2,
    S_VALID = 2'd3
  } ifetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Opcodes seen by the main decoder on instr[31:26]
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

endpackage

// File: rtl/pc_next.sv
// rtl/pc_next.sv - combinational next-pc select: jump, then taken branch, then pc+4
module pc_next (
  input  logic [31:0] i_pcplus4,
  input  logic        i_jump,
  input  logic        i_branch_taken,
  input  logic [25:0] i_jaddr,
  input  logic [31:0] i_branch_off,
  output logic [31:0] o_next_pc
);

  logic [31:0] w_jump_target;
  logic [31:0] w_branch_target;

  // Branch offset is in words; the add wraps modulo 2^32
  assign w_jump_target   = {i_pcplus4[31:28], i_jaddr, 2'b00};
  assign w_branch_target = i_pcplus4 + {i_branch_off[29:0], 2'b00};

  always_comb begin
    o_next_pc = i_pcplus4;
    if (i_jump) begin
      o_next_pc = w_jump_target;
    end else if (i_branch_taken) begin
      o_next_pc = w_branch_target;
    end
  end

endmodule

// File: rtl/ifetch.sv
// rtl/ifetch.sv - instruction fetch FSM with timeout; IFETCH_PERF_EN enables perf counters
module ifetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = DEFAULT_RESET_PC,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic [31:0] pc,
  output logic [31:0] pcplus4,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        jump,
  input  logic        branch_taken,
  input  logic [25:0] jaddr,
  input  logic [31:0] branch_off,
  output logic        imem_err,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
);

  localparam int            TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  ifetch_state_t r_state;
  ifetch_state_t w_state_nxt;
  logic [31:0]   r_pc;
  logic [31:0]   r_instr;
  logic [TW-1:0] r_tmo;
  logic          r_err;
  logic [31:0]   w_pcplus4;
  logic [31:0]   w_next_pc;
  logic          w_req;
  logic          w_capture;
  logic          w_accept;
  logic          w_timeout;

  assign w_pcplus4 = r_pc + 32'd4;

  pc_next u_pc_next (
    .i_pcplus4      (w_pcplus4),
    .i_jump         (jump),
    .i_branch_taken (branch_taken),
    .i_jaddr        (jaddr),
    .i_branch_off   (branch_off),
    .o_next_pc      (w_next_pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_capture   = 1'b0;
    w_accept    = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        w_req = 1'b1;
        if (imem_ack) begin
          w_capture   = 1'b1;
          w_state_nxt = S_VALID;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        w_req = 1'b1;
        if (imem_ack) begin
          w_capture   = 1'b1;
          w_state_nxt = S_VALID;
        end else if (r_tmo == TMO_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_VALID: begin
        if (instr_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // pc only moves on acceptance, so a timeout refetches the same address
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc    <= {RESET_PC[31:2], 2'b00};
      r_instr <= 32'd0;
      r_tmo   <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_capture) begin
        r_instr <= imem_rdata;
      end
      if (w_accept) begin
        r_pc <= w_next_pc;
      end
      if (w_timeout) begin
        r_err <= 1'b1;
      end
      if ((r_state == S_WAIT) && !imem_ack && !w_timeout) begin
        r_tmo <= r_tmo + 1'b1;
      end else begin
        r_tmo <= '0;
      end
    end
  end

`ifdef IFETCH_PERF_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;
  logic        w_stall;

  assign w_stall = (r_state == S_WAIT) || ((r_state == S_VALID) && !instr_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_cnt <= 32'd0;
      r_stall_cnt <= 32'd0;
    end else begin
      if (w_capture) begin
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
      if (w_stall) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign fetch_cnt = r_fetch_cnt;
  assign stall_cnt = r_stall_cnt;
`else
  assign fetch_cnt = 32'd0;
  assign stall_cnt = 32'd0;
`endif

  assign imem_addr   = r_pc;
  assign imem_req    = w_req;
  assign instr       = r_instr;
  assign op          = r_instr[31:26];
  assign funct       = r_instr[5:0];
  assign pc          = r_pc;
  assign pcplus4     = w_pcplus4;
  assign instr_valid = (r_state == S_VALID);
  assign imem_err    = r_err;

endmodule

// File: tb/tb_ifetch.sv
// tb/tb_ifetch.sv - directed self-checking bench for ifetch
module tb_ifetch;

  logic        clk;
  logic        reset;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic [31:0] pc;
  logic [31:0] pcplus4;
  logic        instr_valid;
  logic        instr_ready;
  logic        jump;
  logic        branch_taken;
  logic [25:0] jaddr;
  logic [31:0] branch_off;
  logic        imem_err;
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef IFETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  ifetch dut (
    .clk          (clk),
    .reset        (reset),
    .imem_addr    (imem_addr),
    .imem_req     (imem_req),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .op           (op),
    .funct        (funct),
    .pc           (pc),
    .pcplus4      (pcplus4),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .jump         (jump),
    .branch_taken (branch_taken),
    .jaddr        (jaddr),
    .branch_off   (branch_off),
    .imem_err     (imem_err),
    .fetch_cnt    (fetch_cnt),
    .stall_cnt    (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; instr_ready = 1'b0;
    jump = 1'b0; branch_taken = 1'b0; jaddr = 26'd0; branch_off = 32'd0;
    step(); step();
    chk("rst_req", imem_req, 1'b0);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_err", imem_err, 1'b0);
    chk("rst_fcnt", fetch_cnt, 32'd0);
    chk("rst_scnt", stall_cnt, 32'd0);

    reset = 1'b0; imem_ack = 1'b0;
    step();
    chk("f0_req", imem_req, 1'b1);
    chk("f0_addr", imem_addr, 32'h0);
    chk("f0_valid", instr_valid, 1'b0);

    imem_ack = 1'b1; imem_rdata = 32'h2002_0005; instr_ready = 1'b1;
    step();
    chk("v0_valid", instr_valid, 1'b1);
    chk("v0_instr", instr, 32'h2002_0005);
    chk("v0_op", op, 6'h08);
    chk("v0_funct", funct, 6'h05);
    chk("v0_pc", pc, 32'h0);
    chk("v0_pc4", pcplus4, 32'h4);
    chk("v0_req", imem_req, 1'b0);
    step();
    chk("f1_addr", imem_addr, 32'h4);
    chk("f1_req", imem_req, 1'b1);
    chk("f1_valid", instr_valid, 1'b0);

    imem_rdata = 32'h0022_1820;
    step();
    chk("v1_valid", instr_valid, 1'b1);
    chk("v1_op", op, 6'h00);
    chk("v1_funct", funct, 6'h20);
    chk("v1_pc", pc, 32'h4);
    step();
    chk("f2_addr", imem_addr, 32'h8);

    imem_ack = 1'b0;
    step();
    chk("w1_req", imem_req, 1'b1);
    chk("w1_valid", instr_valid, 1'b0);
    step();
    chk("w2_req", imem_req, 1'b1);
    step();
    chk("w3_req", imem_req, 1'b1);
    imem_ack = 1'b1; imem_rdata = 32'h0800_0040; instr_ready = 1'b0;
    step();
    chk("v2_valid", instr_valid, 1'b1);
    chk("v2_instr", instr, 32'h0800_0040);
    chk("v2_op", op, 6'h02);

    imem_rdata = 32'hFFFF_FFFF; jump = 1'b1; jaddr = 26'h40;
    step();
    chk("hold1_valid", instr_valid, 1'b1);
    chk("hold1_instr", instr, 32'h0800_0040);
    chk("hold1_pc", pc, 32'h8);
    step();
    chk("hold2_instr", instr, 32'h0800_0040);
    chk("hold2_pc", pc, 32'h8);
    chk("hold2_funct", funct, 6'h00);
    chk("stall_cnt", stall_cnt, PERF ? 32'd5 : 32'd0);
    chk("fetch_cnt", fetch_cnt, PERF ? 32'd3 : 32'd0);

    instr_ready = 1'b1; imem_ack = 1'b0;
    step();
    chk("jmp_addr", imem_addr, 32'h100);
    chk("jmp_req", imem_req, 1'b1);

    imem_ack = 1'b1; imem_rdata = 32'h1000_FFFE;
    jump = 1'b1; branch_taken = 1'b1; jaddr = 26'h40; branch_off = 32'd5;
    step();
    chk("v3_pc", pc, 32'h100);
    step();
    chk("jwin_addr", imem_addr, 32'h100);

    jump = 1'b0; branch_taken = 1'b1; branch_off = 32'hFFFF_FFFE;
    step();
    chk("v4_valid", instr_valid, 1'b1);
    step();
    chk("bneg_addr", imem_addr, 32'hFC);

    branch_off = 32'hFFFF_FFBF;
    step();
    step();
    chk("bwrap_addr", imem_addr, 32'hFFFF_FFFC);

    branch_taken = 1'b0;
    step();
    chk("top_pc", pc, 32'hFFFF_FFFC);
    chk("top_pc4", pcplus4, 32'h0);
    imem_ack = 1'b0;
    step();
    chk("wrap_addr", imem_addr, 32'h0);

    step();
    for (int i = 0; i < 15; i++) step();
    chk("tmo_pre_err", imem_err, 1'b0);
    chk("tmo_pre_req", imem_req, 1'b1);
    step();
    chk("tmo_err", imem_err, 1'b1);
    chk("tmo_idle_req", imem_req, 1'b0);
    chk("tmo_idle_valid", instr_valid, 1'b0);
    step();
    chk("refetch_addr", imem_addr, 32'h0);
    chk("refetch_req", imem_req, 1'b1);

    imem_ack = 1'b1; imem_rdata = 32'hAC00_0000; jump = 1'b1; jaddr = 26'h10;
    step();
    chk("v5_op", op, 6'h2B);
    chk("err_sticky", imem_err, 1'b1);
    imem_ack = 1'b0;
    step();
    chk("f6_addr", imem_addr, 32'h40);
    jump = 1'b0;
    step();
    chk("w6_req", imem_req, 1'b1);

    reset = 1'b1;
    step();
    chk("rst2_req", imem_req, 1'b0);
    chk("rst2_pc", pc, 32'h0);
    chk("rst2_err", imem_err, 1'b0);
    chk("rst2_instr", instr, 32'h0);
    chk("rst2_fcnt", fetch_cnt, 32'd0);

    reset = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    step();
    chk("late_ack_instr", instr, 32'h0);
    chk("late_ack_valid", instr_valid, 1'b0);
    chk("restart_addr", imem_addr, 32'h0);
    chk("restart_req", imem_req, 1'b1);
    step();
    chk("restart_valid", instr_valid, 1'b1);
    chk("restart_instr", instr, 32'h1234_5678);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
